// File: rtl/cpu_reg_file.sv
// ---------------------------------------------------------------------------
// cpu_reg_file
//
// Integer register file for the RV32I core: 2**ADDR_WIDTH registers of
// DATA_WIDTH bits, two combinational read ports (rs1/rs2) and one
// synchronous write port (rd). Register x0 always reads zero and ignores
// writes.
//
// Ports:
//   clk           in   1           system clock, rising edge active
//   reset         in   1           synchronous, active-high; clears all regs
//   write_enable  in   1           commit write_data to write_reg at the edge
//   write_reg     in   ADDR_WIDTH  destination index (rd)
//   write_data    in   DATA_WIDTH  value to write
//   read_reg1     in   ADDR_WIDTH  read port 1 index (rs1)
//   read_data1    out  DATA_WIDTH  contents of read_reg1
//   read_reg2     in   ADDR_WIDTH  read port 2 index (rs2)
//   read_data2    out  DATA_WIDTH  contents of read_reg2
//
// Interface semantics: there is no valid/ready handshake. A write happens on
// every rising edge where write_enable is high; reads are always valid and
// follow their index and the storage combinationally. There is no
// write-to-read bypass: a read of the register being written shows the old
// value until the edge, the new value after it.
// ---------------------------------------------------------------------------
module cpu_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    output logic [DATA_WIDTH-1:0] read_data1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Entry 0 exists only to keep the array dense; it is never written
    // (other than cleared by reset) and the read muxes mask it to zero.
    logic [DATA_WIDTH-1:0] regs [0:NUM_REGS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable && (write_reg != '0)) begin
            regs[write_reg] <= write_data;
        end
    end

    // x0 is forced to zero at the read port, so it is correct even before
    // the first reset edge when the storage is still undefined.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (read_reg1 != '0) begin
            read_data1 = regs[read_reg1];
        end
        if (read_reg2 != '0) begin
            read_data2 = regs[read_reg2];
        end
    end

endmodule

// File: tb/tb_cpu_reg_file.sv
// ---------------------------------------------------------------------------
// tb_cpu_reg_file
//
// Directed bench for cpu_reg_file. The driver changes inputs 1 time unit
// after each rising edge and pushes the hand-computed read values expected
// for that cycle into exp_q. The monitor samples both read ports on the
// falling edge, pops one entry and compares.
// ---------------------------------------------------------------------------
module tb_cpu_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;

    // Clock / reset
    logic          clk;
    logic          reset;
    logic          write_enable;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_reg1;
    logic [DW-1:0] read_data1;
    logic [AW-1:0] read_reg2;
    logic [DW-1:0] read_data2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cpu_reg_file #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write_enable(write_enable),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .read_reg1   (read_reg1),
        .read_data1  (read_data1),
        .read_reg2   (read_reg2),
        .read_data2  (read_data2)
    );

    // Scoreboard
    logic [2*DW-1:0] exp_q[$];
    string           tag_q[$];
    int              checks = 0;
    int              passed = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [2*DW-1:0] e;
            string           t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (read_data1 === e[2*DW-1:DW]) passed++;
            else $display("FAIL %s port1: got %h expected %h", t, read_data1, e[2*DW-1:DW]);
            checks++;
            if (read_data2 === e[DW-1:0]) passed++;
            else $display("FAIL %s port2: got %h expected %h", t, read_data2, e[DW-1:0]);
        end
    end

    // Driver tasks
    task automatic drive(input logic rst, input logic we, input logic [AW-1:0] wr,
                         input logic [DW-1:0] wd, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2);
        reset        = rst;
        write_enable = we;
        write_reg    = wr;
        write_data   = wd;
        read_reg1    = r1;
        read_reg2    = r2;
    endtask

    task automatic expect_rd(input string tag, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        exp_q.push_back({e1, e2});
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        tick();

        // x0 reads zero even before any reset
        expect_rd("x0_pre_reset", 32'h0, 32'h0);
        tick();

        // Reset clears everything
        drive(1'b1, 1'b0, '0, '0, 5'd5, 5'd31);
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd5, 5'd31);
        expect_rd("reset_all_a", 32'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd17, 5'd30);
        expect_rd("reset_all_b", 32'h0, 32'h0);
        tick();

        // Reset clear of a written register
        drive(1'b0, 1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5);
        expect_rd("x5_before_write", 32'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd5, 5'd5);
        expect_rd("x5_written", 32'h12345678, 32'h12345678);
        tick();
        drive(1'b1, 1'b0, '0, '0, 5'd5, 5'd5);
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd5, 5'd5);
        expect_rd("reset_clear_x5", 32'h0, 32'h0);
        tick();

        // Basic write/read
        drive(1'b0, 1'b1, 5'd1, 32'hAAAAAAAA, 5'd1, 5'd0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd1, 5'd0);
        expect_rd("basic_x1", 32'hAAAAAAAA, 32'h0);
        tick();

        // Second register, dual-port read
        drive(1'b0, 1'b1, 5'd8, 32'hFFFFFFFF, 5'd8, 5'd1);
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd8, 5'd1);
        expect_rd("dual_x8_x1", 32'hFFFFFFFF, 32'hAAAAAAAA);
        tick();

        // x0 hardwired: repeated writes are discarded
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 5'd0, 32'hCCCCCCCC, 5'd0, 5'd1);
            expect_rd("x0_write_ignored", 32'h0, 32'hAAAAAAAA);
            tick();
        end
        drive(1'b0, 1'b0, '0, '0, 5'd1, 5'd8);
        expect_rd("x1_x8_kept", 32'hAAAAAAAA, 32'hFFFFFFFF);
        tick();

        // Write disable
        drive(1'b0, 1'b1, 5'd3, 32'h33333333, 5'd0, 5'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 5'd3, 32'hDEADBEEF, 5'd3, 5'd3);
            expect_rd("we_off_hold_x3", 32'h33333333, 32'h33333333);
            tick();
        end

        // Reset priority over a simultaneous write
        drive(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd8);
        tick();
        drive(1'b1, 1'b1, 5'd7, 32'h77777777, 5'd3, 5'd7);
        expect_rd("reset_priority", 32'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd3, 5'd7);
        expect_rd("reset_held_no_write", 32'h0, 32'h0);
        tick();

        // Read-during-write, no bypass
        drive(1'b0, 1'b1, 5'd4, 32'h11111111, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 5'd4, 32'h22222222, 5'd4, 5'd4);
        expect_rd("rdw_before", 32'h11111111, 32'h11111111);
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd4, 5'd4);
        expect_rd("rdw_after", 32'h22222222, 32'h22222222);
        tick();

        // Top index
        drive(1'b0, 1'b1, 5'd31, 32'h5A5A5A5A, 5'd31, 5'd4);
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd31, 5'd4);
        expect_rd("x31_and_x4", 32'h5A5A5A5A, 32'h22222222);
        tick();

        // Let the monitor drain the last entry
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
